// File: rtl/mvm_controller_if.sv
// Load/result handshake bundle between the environment and mvm_controller.
// slave is the controller's view, master the environment's.
interface mvm_controller_if;
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;
  logic m_last;

  modport master (
    output s_valid,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_last
  );

  modport slave (
    input  s_valid,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_last
  );
endinterface

// File: rtl/mvm_controller.sv
// Sequencer for the matrix-vector datapath: load X and A, run M dot
// products into Y, then stream Y out under valid/ready.
module mvm_controller #(
  parameter int M   = 3,
  parameter int N   = 3,
  parameter int XAW = 4,
  parameter int AAW = 2,
  parameter int YAW = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  mvm_controller_if.slave hs,
  output logic           busy,
  output logic [XAW-1:0] addr_x,
  output logic           wr_en_x,
  output logic [AAW-1:0] addr_a,
  output logic           wr_en_a,
  output logic [YAW-1:0] addr_y,
  output logic           wr_en_y,
  output logic           clear_acc
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_A,
    CLEAR,
    MAC,
    WRITE,
    OUTPUT
  } state_t;

  localparam logic [XAW-1:0] KX_LAST  = XAW'(M*N-1);
  localparam logic [XAW-1:0] KA_LAST  = XAW'(N-1);
  localparam logic [YAW-1:0] ROW_LAST = YAW'(M-1);
  localparam logic [AAW-1:0] COL_LAST = AAW'(N-1);
  localparam logic [XAW-1:0] N_X      = XAW'(N);

  state_t         state, state_nxt;
  logic [XAW-1:0] k, k_nxt;
  logic [YAW-1:0] row, row_nxt;
  logic [AAW-1:0] col, col_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      k     <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    row_nxt    = row;
    col_nxt    = col;
    hs.s_ready = 1'b0;
    hs.m_valid = 1'b0;
    hs.m_last  = 1'b0;
    busy       = (state != IDLE);
    addr_x     = '0;
    wr_en_x    = 1'b0;
    addr_a     = '0;
    wr_en_a    = 1'b0;
    addr_y     = '0;
    wr_en_y    = 1'b0;
    clear_acc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_X;
          k_nxt     = '0;
        end
      end
      LOAD_X: begin
        hs.s_ready = 1'b1;
        addr_x     = k;
        wr_en_x    = hs.s_valid;
        if (hs.s_valid) begin
          if (k == KX_LAST) begin
            state_nxt = LOAD_A;
            k_nxt     = '0;
          end else begin
            k_nxt = k + XAW'(1);
          end
        end
      end
      LOAD_A: begin
        hs.s_ready = 1'b1;
        addr_a     = k[AAW-1:0];
        wr_en_a    = hs.s_valid;
        if (hs.s_valid) begin
          if (k == KA_LAST) begin
            state_nxt = CLEAR;
            k_nxt     = '0;
            row_nxt   = '0;
          end else begin
            k_nxt = k + XAW'(1);
          end
        end
      end
      CLEAR: begin
        clear_acc = 1'b1;
        state_nxt = MAC;
        col_nxt   = '0;
      end
      MAC: begin
        // row-major element (row, col) of X
        addr_x = XAW'(row) * N_X + XAW'(col);
        addr_a = col;
        if (col == COL_LAST) begin
          state_nxt = WRITE;
        end else begin
          col_nxt = col + AAW'(1);
        end
      end
      WRITE: begin
        addr_y  = row;
        wr_en_y = 1'b1;
        if (row == ROW_LAST) begin
          state_nxt = OUTPUT;
          row_nxt   = '0;
        end else begin
          state_nxt = CLEAR;
          row_nxt   = row + YAW'(1);
        end
      end
      OUTPUT: begin
        hs.m_valid = 1'b1;
        addr_y     = row;
        hs.m_last  = (row == ROW_LAST);
        if (hs.m_ready) begin
          if (row == ROW_LAST) begin
            state_nxt = IDLE;
            row_nxt   = '0;
          end else begin
            row_nxt = row + YAW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mvm_controller.sv
// Directed bench for mvm_controller with a behavioural datapath model.
// Covers loads with gaps, result stalls, latency, wrap and mid-job reset.
module tb_mvm_controller;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              busy;
  logic [3:0]        addr_x;
  logic              wr_en_x;
  logic [1:0]        addr_a;
  logic              wr_en_a;
  logic [1:0]        addr_y;
  logic              wr_en_y;
  logic              clear_acc;
  logic signed [7:0] data_in;

  mvm_controller_if hs ();

  mvm_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .hs        (hs),
    .busy      (busy),
    .addr_x    (addr_x),
    .wr_en_x   (wr_en_x),
    .addr_a    (addr_a),
    .wr_en_a   (wr_en_a),
    .addr_y    (addr_y),
    .wr_en_y   (wr_en_y),
    .clear_acc (clear_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model
  logic signed [7:0]  xm [16];
  logic signed [7:0]  am [4];
  logic        [15:0] ym [4];
  logic signed [15:0] f;
  logic signed [15:0] xe;
  logic signed [15:0] ae;
  logic        [15:0] data_out;
  int nx = 0;
  int na = 0;

  assign xe       = 16'(xm[addr_x]);
  assign ae       = 16'(am[addr_a]);
  assign data_out = ym[addr_y];

  always @(posedge clk) begin
    if (wr_en_x) xm[addr_x] <= data_in;
    if (wr_en_a) am[addr_a] <= data_in;
    if (wr_en_y) ym[addr_y] <= f;
    f <= clear_acc ? 16'sd0 : f + xe * ae;
    if (wr_en_x) nx <= nx + 1;
    if (wr_en_a) na <= na + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n)
      check("we_onehot",
            32'(wr_en_x) + 32'(wr_en_a) + 32'(wr_en_y) <= 1, 1);
  end

  logic signed [7:0] tx [9];
  logic signed [7:0] ta [3];

  task automatic set_case1();
    for (int i = 0; i < 9; i++) tx[i] = 8'(i + 1);
    ta[0] = 8'sd1;
    ta[1] = 8'sd2;
    ta[2] = 8'sd3;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ax"}, addr_x, 0);
    check({tag, "_aa"}, addr_a, 0);
    check({tag, "_ay"}, addr_y, 0);
    check({tag, "_we"}, {wr_en_x, wr_en_a, wr_en_y}, 0);
    check({tag, "_clr"}, clear_acc, 0);
    check({tag, "_hs"}, {hs.s_ready, hs.m_valid, hs.m_last}, 0);
  endtask

  // returns at the negedge of the first cycle after the last A load
  task automatic load(input bit gaps, input bit poke);
    int bx;
    int ba;
    bx = nx;
    ba = na;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    for (int i = 0; i < 9; i++) begin
      if (gaps && (i % 2 == 1)) begin
        hs.s_valid = 1'b0;
        data_in    = 8'sh55;
        #1;
        check("x_gap_we", wr_en_x, 0);
        @(negedge clk);
      end
      hs.s_valid = 1'b1;
      data_in    = tx[i];
      if (poke && i == 4) start = 1'b1;
      #1;
      check("x_addr", addr_x, i);
      check("x_we", {hs.s_ready, wr_en_x}, 2'b11);
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (gaps) begin
        hs.s_valid = 1'b0;
        #1;
        check("a_gap_we", wr_en_a, 0);
        @(negedge clk);
      end
      hs.s_valid = 1'b1;
      data_in    = ta[i];
      #1;
      check("a_addr", addr_a, i);
      check("a_we", {hs.s_ready, wr_en_a}, 2'b11);
      @(negedge clk);
    end
    hs.s_valid = 1'b0;
    check("x_writes", nx - bx, 9);
    check("a_writes", na - ba, 3);
    check("clear_first", clear_acc, 1);
  endtask

  task automatic collect(input logic [15:0] y0,
                         input logic [15:0] y1,
                         input logic [15:0] y2,
                         input int stall_row,
                         input bit poke);
    logic [15:0] ey [3];
    int lat;
    ey[0] = y0;
    ey[1] = y1;
    ey[2] = y2;
    lat   = 0;
    while (!hs.m_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 15);
    for (int i = 0; i < 3; i++) begin
      check("m_valid", hs.m_valid, 1);
      if (i == stall_row) begin
        for (int s = 0; s < 4; s++) begin
          hs.m_ready = 1'b0;
          start      = (poke && s == 1);
          #1;
          check("stall_ay", addr_y, i);
          check("stall_mv", hs.m_valid, 1);
          @(negedge clk);
        end
        start = 1'b0;
      end
      check("y_data", data_out, ey[i]);
      check("y_addr", addr_y, i);
      check("m_last", hs.m_last, (i == 2));
      hs.m_ready = 1'b1;
      @(negedge clk);
      hs.m_ready = 1'b0;
    end
    check("done_busy", busy, 0);
    check("done_mv", hs.m_valid, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    hs.s_valid = 1'b0;
    hs.m_ready = 1'b0;
    data_in    = '0;
    f          = '0;
    for (int i = 0; i < 16; i++) xm[i] = '0;
    for (int i = 0; i < 4; i++) am[i] = '0;
    for (int i = 0; i < 4; i++) ym[i] = '0;
    #1;
    check_idle_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    // 1: X=1..9, A=[1,2,3]
    set_case1();
    load(0, 0);
    collect(16'd14, 16'd32, 16'd50, -1, 0);

    // 2: identity X, A=[5,-3,7]
    for (int i = 0; i < 9; i++) tx[i] = (i % 4 == 0) ? 8'sd1 : 8'sd0;
    ta[0] = 8'sd5;
    ta[1] = -8'sd3;
    ta[2] = 8'sd7;
    load(0, 0);
    collect(16'd5, 16'hFFFD, 16'd7, -1, 0);

    // 3: all -128 wraps to 0xC000
    for (int i = 0; i < 9; i++) tx[i] = -8'sd128;
    for (int i = 0; i < 3; i++) ta[i] = -8'sd128;
    load(0, 0);
    collect(16'hC000, 16'hC000, 16'hC000, -1, 0);

    // 4 and 6: gapped load, stall on y[1], start pokes
    set_case1();
    load(1, 1);
    collect(16'd14, 16'd32, 16'd50, 1, 1);

    // 5: reset during MAC of row 1
    for (int i = 0; i < 16; i++) xm[i] = 8'sh7F;
    for (int i = 0; i < 4; i++) am[i] = 8'sh7F;
    set_case1();
    load(0, 0);
    repeat (7) @(negedge clk);
    check("mac_r1_ax", addr_x, 4);
    check("mac_r1_aa", addr_a, 1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) tx[i] = 8'(i + 1);
    load(0, 0);
    collect(16'd14, 16'd32, 16'd50, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
